// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns MEM-stage loads/stores into single-beat bus transactions
// and stalls the pipeline until they complete. Optional misaligned-access trap: MISALIGN_TRAP_EN.
module dmem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_ex_mem_o,
    input  logic        MemWrite_ex_mem_o,
    input  logic [2:0]  funct3_ex_mem_o,
    input  logic [31:0] ALU_result_ex_mem_o,
    input  logic [31:0] Rs2_data_ex_mem_o,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        misalign_exc
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // funct3[1:0] carries the size; every encoding other than B/H/BU/HU behaves as a word.
    function automatic size_t decode_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    state_t      state, next_state;
    size_t       req_size, size_q;
    logic        unsigned_q;
    logic [1:0]  lane_q;
    logic        access_req;
    logic        trap;
    logic        capture;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] ext_data;
    logic [31:0] rdata_shifted;

    assign access_req = MemRead_ex_mem_o | MemWrite_ex_mem_o;
    assign req_size   = decode_size(funct3_ex_mem_o);

`ifdef MISALIGN_TRAP_EN
    assign trap = access_req &&
                  (((req_size == SZ_H) && ALU_result_ex_mem_o[0]) ||
                   ((req_size == SZ_W) && (ALU_result_ex_mem_o[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        next_state = state;
        mem_stall  = 1'b0;
        bus_req    = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (access_req && !trap) begin
                    mem_stall  = 1'b1;
                    capture    = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                bus_req   = 1'b1;
                mem_stall = 1'b1;
                if (bus_ack) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Store data is replicated across lanes so the strobes alone pick the bytes written.
    always_comb begin
        req_wdata = Rs2_data_ex_mem_o;
        req_wstrb = 4'b1111;
        case (req_size)
            SZ_B: begin
                req_wdata = {4{Rs2_data_ex_mem_o[7:0]}};
                req_wstrb = 4'b0001 << ALU_result_ex_mem_o[1:0];
            end
            SZ_H: begin
                req_wdata = {2{Rs2_data_ex_mem_o[15:0]}};
                req_wstrb = ALU_result_ex_mem_o[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                req_wdata = Rs2_data_ex_mem_o;
                req_wstrb = 4'b1111;
            end
        endcase
    end

    assign rdata_shifted = bus_rdata >> {lane_q, 3'b000};

    always_comb begin
        ext_data = bus_rdata;
        case (size_q)
            SZ_B: ext_data = unsigned_q ? {24'h0, rdata_shifted[7:0]}
                                        : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            SZ_H: begin
                if (lane_q[1])
                    ext_data = unsigned_q ? {16'h0, bus_rdata[31:16]}
                                          : {{16{bus_rdata[31]}}, bus_rdata[31:16]};
                else
                    ext_data = unsigned_q ? {16'h0, bus_rdata[15:0]}
                                          : {{16{bus_rdata[15]}}, bus_rdata[15:0]};
            end
            default: ext_data = bus_rdata;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Request attributes are latched on entry to WAIT and held stable until the ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr   <= 32'h0;
            bus_we     <= 1'b0;
            bus_wdata  <= 32'h0;
            bus_wstrb  <= 4'b0000;
            size_q     <= SZ_W;
            unsigned_q <= 1'b0;
            lane_q     <= 2'b00;
        end else if (capture) begin
            bus_addr   <= {ALU_result_ex_mem_o[31:2], 2'b00};
            bus_we     <= MemWrite_ex_mem_o;
            bus_wdata  <= MemWrite_ex_mem_o ? req_wdata : 32'h0;
            bus_wstrb  <= MemWrite_ex_mem_o ? req_wstrb : 4'b0000;
            size_q     <= req_size;
            unsigned_q <= funct3_ex_mem_o[2];
            lane_q     <= ALU_result_ex_mem_o[1:0];
        end
    end

    // bus_rdata is only looked at in the ack cycle of a load; load_valid therefore lands in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_data  <= 32'h0;
            load_valid <= 1'b0;
        end else begin
            load_valid <= (state == WAIT) && bus_ack && !bus_we;
            if ((state == WAIT) && bus_ack && !bus_we)
                load_data <= ext_data;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_exc <= 1'b0;
        else        misalign_exc <= (state == IDLE) && trap;
    end
`else
    assign misalign_exc = 1'b0;
`endif

endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have ports clk (in, 1, the only clock) and rst_n (in, 1); reset is asynchronous and active-low.
REQ-002 SHALL have MemRead_ex_mem_o (in, 1): the MEM-stage instruction is a load.
REQ-003 SHALL have MemWrite_ex_mem_o (in, 1): the MEM-stage instruction is a store.
REQ-004 SHALL have funct3_ex_mem_o (in, 3): access size/sign; 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-005 SHALL have ALU_result_ex_mem_o (in, 32): byte address of the access.
REQ-006 SHALL have Rs2_data_ex_mem_o (in, 32): store data, right-aligned.
REQ-007 SHALL have mem_stall (out, 1): freezes the PC and all pipeline registers while high.
REQ-008 SHALL have load_data (out, 32), the extended load result, and load_valid (out, 1), a one-cycle strobe.
REQ-009 SHALL have the bus ports: bus_req out 1, bus_we out 1, bus_addr out 32 (addr[1:0]=00), bus_wdata out 32, bus_wstrb out 4, bus_ack in 1, bus_rdata in 32.
REQ-010 SHALL have misalign_exc (out, 1): one-cycle misaligned-access exception pulse.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-012 IDLE: on MemRead|MemWrite, mem_stall SHALL be high combinationally in that cycle, with next state WAIT.
REQ-013 WAIT: bus_req=1, mem_stall=1, and addr/we/wdata/wstrb SHALL be registered and stable; on bus_ack the next state is DONE.
REQ-014 DONE: mem_stall SHALL be 0 so the instruction retires, with no new request issued; the next state is IDLE unconditionally.
REQ-015 Minimum latency SHALL be: request seen in cycle N, bus_req in N+1, ack accepted in N+1 at earliest, DONE in N+2; the stall lasts 2 cycles.
REQ-016 When both MemRead and MemWrite are high, the access SHALL be treated as a store.
REQ-017 Store strobes SHALL be: SB = one lane selected by addr[1:0] with data byte replicated ×4; SH = lanes by addr[1] with half replicated ×2; SW = 1111.
REQ-018 Loads SHALL select the lane by addr[1:0] (byte) or addr[1] (half), then sign-extend (B, H) or zero-extend (BU, HU); unlisted funct3 values SHALL be treated as W.
REQ-019 load_data SHALL be registered on the ack cycle of a load and held until the next load ack; load_valid SHALL be high in DONE for loads only.
REQ-020 bus_ack outside WAIT SHALL be ignored.
REQ-021 bus_rdata SHALL be sampled only in the ack cycle.

Reset
REQ-022 On rst_n low, state SHALL go to IDLE and bus_req, bus_we, bus_wstrb, load_valid and misalign_exc SHALL go to 0; load_data, bus_addr and bus_wdata SHALL go to 0.
REQ-023 Reset asserted in WAIT SHALL drop bus_req immediately, with no completion reported; a late ack after reset release SHALL be ignored per REQ-020.

Configuration
REQ-024 Macro MISALIGN_TRAP_EN defined: in IDLE, a misaligned access (H with addr[0]=1; W with addr[1:0]≠00) SHALL issue no bus transaction, assert no mem_stall, pulse misalign_exc for 1 cycle, and return to IDLE.
REQ-025 Macro MISALIGN_TRAP_EN undefined: a misaligned access SHALL be issued as in REQ-017/018 using only the lane-select bits, and misalign_exc SHALL be tied 0.

Verification
REQ-026 LW addr 0x100, ack in the first WAIT cycle, rdata 0xDEADBEEF -> stall 2 cycles, load_data=0xDEADBEEF, load_valid one pulse.
REQ-027 LB addr 0x103, rdata 0x80000000, ack after 3 WAIT cycles -> load_data=0xFFFFFF80, stall 4 cycles; LBU same -> 0x00000080.
REQ-028 SH addr 0x202, Rs2=0x1234ABCD -> bus_addr=0x200, wstrb=1100, wdata=0xABCDABCD, we=1, load_valid stays 0.
REQ-029 rst_n low during WAIT, ack arrives 1 cycle after release -> bus_req drops asynchronously, FSM stays IDLE, no load_valid.
REQ-030 LW addr 0x102 -> with MISALIGN_TRAP_EN: misalign_exc pulses, bus_req never 1, mem_stall 0; without: bus_addr=0x100, normal completion.
